// File: rtl/udp_seq_bank.sv
`default_nettype none
// ============================================================================
// Module      : udp_seq_bank
// Description : Bank of CH run-time programmable primitives. Each channel
//               looks up its N_IN inputs in a truth table to produce a
//               registered output. In sequential mode the channel's current
//               output is used as an extra, most-significant table index bit,
//               which gives UDP-style state behaviour. Tables are reloaded
//               one channel at a time through a valid/ready config port.
//
// Ports       : clk        rising-edge clock
//               rst        synchronous active-high reset
//               in_data    channel c inputs at [c*N_IN +: N_IN]
//               en         per-channel evaluate enable
//               mode_seq   per-channel mode (0 = comb, 1 = sequential)
//               cfg_valid  config request
//               cfg_ready  config port can accept
//               cfg_ch     target channel of the config request
//               cfg_tbl    new truth table for that channel
//               cfg_err    one-cycle pulse: request for a channel >= CH
//               out        registered channel outputs
//               out_chg    one-cycle pulse: out[c] changed on the last edge
//
// Revision    : 1.0 - initial release
// ============================================================================
module udp_seq_bank #(
    parameter int                              N_IN     = 2,
    parameter int                              CH       = 4,
    parameter logic [(2**(N_IN+1))-1:0]        TBL_INIT = 'h08
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CH*N_IN-1:0]          in_data,
    input  logic [CH-1:0]               en,
    input  logic [CH-1:0]               mode_seq,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [3:0]                  cfg_ch,
    input  logic [(2**(N_IN+1))-1:0]    cfg_tbl,
    output logic                        cfg_err,
    output logic [CH-1:0]               out,
    output logic [CH-1:0]               out_chg
);

    localparam int TBL_W = 2**(N_IN+1);

    // ------------------------------------------------------------------
    // Config FSM state encoding
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_COMMIT = 1'b1
    } state_t;

    state_t             r_state;
    logic               r_ready;
    logic               r_err;
    logic [3:0]         r_ch;
    logic [TBL_W-1:0]   r_new_tbl;

    logic [TBL_W-1:0]   r_tbl [CH];
    logic [CH-1:0]      r_out;
    logic [CH-1:0]      r_chg;

    // ------------------------------------------------------------------
    // Per-channel lookup
    // ------------------------------------------------------------------
    logic [N_IN:0]      w_idx [CH];
    logic [CH-1:0]      w_next;
    logic [CH-1:0]      w_frz;
    logic               w_ch_ok;

    // cfg_ch is 4 bits while CH can be 16, so compare one bit wider.
    assign w_ch_ok = ({1'b0, cfg_ch} < 5'(CH));

    generate
        for (genvar c = 0; c < CH; c++) begin : g_ch
            // In comb mode the state bit is forced to 0 so only the lower
            // half of the table is used.
            assign w_idx[c]  = {mode_seq[c] & r_out[c], in_data[c*N_IN +: N_IN]};
            assign w_next[c] = r_tbl[c][w_idx[c]];
            // The channel being committed holds its output for that cycle;
            // it sees the new table only from the following edge.
            assign w_frz[c]  = (r_state == ST_COMMIT) && (r_ch == 4'(c));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Sequential state: config FSM, tables and channel outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ready   <= 1'b1;
            r_err     <= 1'b0;
            r_ch      <= 4'd0;
            r_new_tbl <= '0;
            r_out     <= '0;
            r_chg     <= '0;
            for (int c = 0; c < CH; c++) begin
                r_tbl[c] <= TBL_INIT;
            end
        end else begin
            r_err <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (cfg_valid && r_ready) begin
                        if (w_ch_ok) begin
                            r_ch      <= cfg_ch;
                            r_new_tbl <= cfg_tbl;
                            r_state   <= ST_COMMIT;
                            r_ready   <= 1'b0;
                        end else begin
                            r_err     <= 1'b1;
                        end
                    end
                end
                ST_COMMIT: begin
                    // Table write happens via the per-channel loop below.
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase

            // Evaluation reads the old table on the commit edge; the frozen
            // channel is exactly the one being written, so no channel ever
            // evaluates against a half-updated table.
            for (int c = 0; c < CH; c++) begin
                if (w_frz[c]) begin
                    r_tbl[c] <= r_new_tbl;
                end
                if (en[c] && !w_frz[c]) begin
                    r_out[c] <= w_next[c];
                    r_chg[c] <= w_next[c] ^ r_out[c];
                end else begin
                    r_chg[c] <= 1'b0;
                end
            end
        end
    end

    assign cfg_ready = r_ready;
    assign cfg_err   = r_err;
    assign out       = r_out;
    assign out_chg   = r_chg;

endmodule
`default_nettype wire
